// File: rtl/vga_scan_gen.sv
// vga_scan_gen: raster scan generator for 640x480@60 from a 50 MHz clock with sync, blank and frame/line pulses
module vga_scan_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       line_end,
    output logic       frame_start
);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       r_pix_en;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank_n;
    logic       r_line_end;
    logic       r_frame_start;
    logic       w_pix_en;
    logic       w_x_last;
    logic       w_y_last;
    logic [9:0] w_x;
    logic [9:0] w_y;

    // next scan position: counters move only on cycles where the pixel enable is high
    always_comb begin
        w_pix_en = ~r_pix_en;
        w_x_last = (r_x == H_LAST);
        w_y_last = (r_y == V_LAST);
        w_x      = r_pix_en ? (w_x_last ? '0 : r_x + 10'd1) : r_x;
        w_y      = (r_pix_en && w_x_last) ? (w_y_last ? '0 : r_y + 10'd1) : r_y;
    end

    // sync, blank and pulses are decoded from the next position so they line up with DrawX/DrawY
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pix_en      <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank_n     <= 1'b1;
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_en      <= w_pix_en;
            r_x           <= w_x;
            r_y           <= w_y;
            r_hs          <= !(w_x >= HS_START && w_x < HS_END);
            r_vs          <= !(w_y >= VS_START && w_y < VS_END);
            r_blank_n     <= (w_x < H_VIS) && (w_y < V_VIS);
            r_line_end    <= w_pix_en && (w_x == H_LAST);
            r_frame_start <= r_pix_en && w_x_last && w_y_last;
        end
    end

    assign pix_en      = r_pix_en;
    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign line_end    = r_line_end;
    assign frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: scoreboard bench for vga_scan_gen, full-size line timing plus a shrunk-raster frame
module tb_vga_scan_gen;
    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic       a_pix, a_hs, a_vs, a_blank, a_syncn, a_le, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_pix, b_hs, b_vs, b_blank, b_syncn, b_le, b_fs;
    logic [9:0] b_x, b_y;

    vga_scan_gen u_a (
        .Clk(clk), .Reset(rst_a), .pix_en(a_pix), .DrawX(a_x), .DrawY(a_y),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_blank), .VGA_SYNC_N(a_syncn),
        .line_end(a_le), .frame_start(a_fs)
    );

    vga_scan_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) u_b (
        .Clk(clk), .Reset(rst_b), .pix_en(b_pix), .DrawX(b_x), .DrawY(b_y),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_blank), .VGA_SYNC_N(b_syncn),
        .line_end(b_le), .frame_start(b_fs)
    );

    localparam int A_PIX = 0, A_X = 1, A_Y = 2, A_HS = 3, A_VS = 4, A_BLANK = 5, A_SYNCN = 6, A_LE = 7, A_FS = 8;
    localparam int A_LE_CNT = 9, A_HS_LOW = 10, A_HS_FX = 11, A_MAX_X = 12, A_MAX_Y = 13, A_SYNCN_CNT = 14;
    localparam int B_X = 20, B_Y = 21, B_HS = 22, B_VS = 23, B_BLANK = 24, B_LE = 25, B_FS = 26, B_PIX = 27;
    localparam int B_FS_CNT = 28, B_VS_LOW = 29, B_BLANK_HI = 30, B_MAX_X = 31, B_MAX_Y = 32, B_SYNCN_CNT = 33;

    typedef struct {
        int    c;
        int    sel;
        int    exp;
        string name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   base, base_b, base2;

    int a_le_cnt, a_hs_low, a_hs_fx, a_max_x, a_max_y, a_syncn_cnt;
    logic a_hs_prev;
    int b_fs_cnt, b_vs_low, b_blank_hi, b_max_x, b_max_y, b_syncn_cnt;

    always #10 clk = ~clk;

    // cycle index shared by stimulus and monitor
    always @(posedge clk) cyc <= cyc + 1;

    // running statistics, each covering the cycles before the current one since its DUT left reset
    always @(negedge clk) begin
        if (rst_a) begin
            a_le_cnt <= 0; a_hs_low <= 0; a_hs_fx <= -1; a_max_x <= 0; a_max_y <= 0; a_syncn_cnt <= 0; a_hs_prev <= 1'b1;
        end else begin
            a_le_cnt    <= a_le_cnt + 32'(a_le);
            a_hs_low    <= a_hs_low + 32'(!a_hs);
            a_hs_fx     <= (!a_hs && a_hs_prev) ? 32'(a_x) : a_hs_fx;
            a_hs_prev   <= a_hs;
            a_max_x     <= (32'(a_x) > a_max_x) ? 32'(a_x) : a_max_x;
            a_max_y     <= (32'(a_y) > a_max_y) ? 32'(a_y) : a_max_y;
            a_syncn_cnt <= a_syncn_cnt + 32'(a_syncn);
        end
        if (rst_b) begin
            b_fs_cnt <= 0; b_vs_low <= 0; b_blank_hi <= 0; b_max_x <= 0; b_max_y <= 0; b_syncn_cnt <= 0;
        end else begin
            b_fs_cnt    <= b_fs_cnt + 32'(b_fs);
            b_vs_low    <= b_vs_low + 32'(!b_vs);
            b_blank_hi  <= b_blank_hi + 32'(b_blank);
            b_max_x     <= (32'(b_x) > b_max_x) ? 32'(b_x) : b_max_x;
            b_max_y     <= (32'(b_y) > b_max_y) ? 32'(b_y) : b_max_y;
            b_syncn_cnt <= b_syncn_cnt + 32'(b_syncn);
        end
    end

    function automatic int get(input int sel);
        case (sel)
            A_PIX: get = 32'(a_pix);
            A_X: get = 32'(a_x);
            A_Y: get = 32'(a_y);
            A_HS: get = 32'(a_hs);
            A_VS: get = 32'(a_vs);
            A_BLANK: get = 32'(a_blank);
            A_SYNCN: get = 32'(a_syncn);
            A_LE: get = 32'(a_le);
            A_FS: get = 32'(a_fs);
            A_LE_CNT: get = a_le_cnt;
            A_HS_LOW: get = a_hs_low;
            A_HS_FX: get = a_hs_fx;
            A_MAX_X: get = a_max_x;
            A_MAX_Y: get = a_max_y;
            A_SYNCN_CNT: get = a_syncn_cnt;
            B_X: get = 32'(b_x);
            B_Y: get = 32'(b_y);
            B_HS: get = 32'(b_hs);
            B_VS: get = 32'(b_vs);
            B_BLANK: get = 32'(b_blank);
            B_LE: get = 32'(b_le);
            B_FS: get = 32'(b_fs);
            B_PIX: get = 32'(b_pix);
            B_FS_CNT: get = b_fs_cnt;
            B_VS_LOW: get = b_vs_low;
            B_BLANK_HI: get = b_blank_hi;
            B_MAX_X: get = b_max_x;
            B_MAX_Y: get = b_max_y;
            B_SYNCN_CNT: get = b_syncn_cnt;
            default: get = -1;
        endcase
    endfunction

    // monitor: pops every expectation due this cycle and compares it with the DUT
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].c <= cyc) begin
                checks++;
                if (q[i].c < cyc) begin
                    errors++;
                    $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", q[i].name, q[i].c, cyc);
                end else if (get(q[i].sel) != q[i].exp) begin
                    errors++;
                    $display("FAIL %s @cycle %0d: got %0d, expected %0d", q[i].name, cyc, get(q[i].sel), q[i].exp);
                end
                q.delete(i);
            end
        end
    end

    task automatic expect_at(input int c, input int sel, input int v, input string name);
        q.push_back('{c, sel, v, name});
    endtask

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // stimulus: reset/line checks on the full-size raster, then frame and mid-frame reset on the shrunk raster
    initial begin
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0;
        base = cyc;
        expect_at(base, A_PIX, 0, "a_rst_pix");
        expect_at(base, A_X, 0, "a_rst_x");
        expect_at(base, A_Y, 0, "a_rst_y");
        expect_at(base, A_HS, 1, "a_rst_hs");
        expect_at(base, A_VS, 1, "a_rst_vs");
        expect_at(base, A_BLANK, 1, "a_rst_blank");
        expect_at(base, A_SYNCN, 0, "a_rst_syncn");
        expect_at(base, A_LE, 0, "a_rst_le");
        expect_at(base, A_FS, 0, "a_rst_fs");
        expect_at(base + 1, A_PIX, 1, "a_pix_c1");
        expect_at(base + 1, A_X, 0, "a_x_c1");
        expect_at(base + 2, A_PIX, 0, "a_pix_c2");
        expect_at(base + 2, A_X, 1, "a_x_c2");
        expect_at(base + 3, A_PIX, 1, "a_pix_c3");
        expect_at(base + 1279, A_BLANK, 1, "a_blank_x639");
        expect_at(base + 1280, A_BLANK, 0, "a_blank_x640");
        expect_at(base + 1280, A_X, 640, "a_x_640");
        expect_at(base + 1311, A_HS, 1, "a_hs_x655");
        expect_at(base + 1312, A_HS, 0, "a_hs_x656");
        expect_at(base + 1312, A_X, 656, "a_x_656");
        expect_at(base + 1503, A_HS, 0, "a_hs_x751");
        expect_at(base + 1504, A_HS, 1, "a_hs_x752");
        expect_at(base + 1598, A_LE, 0, "a_le_pix0");
        expect_at(base + 1599, A_LE, 1, "a_le_x799");
        expect_at(base + 1599, A_X, 799, "a_x_799");
        expect_at(base + 1599, A_Y, 0, "a_y_line0");
        expect_at(base + 1600, A_X, 0, "a_x_wrap");
        expect_at(base + 1600, A_Y, 1, "a_y_line1");
        expect_at(base + 1600, A_LE, 0, "a_le_after");
        expect_at(base + 1601, A_LE_CNT, 1, "a_le_count");
        expect_at(base + 1601, A_HS_LOW, 192, "a_hs_low_clk");
        expect_at(base + 1601, A_HS_FX, 656, "a_hs_start_x");
        expect_at(base + 1601, A_MAX_X, 799, "a_max_x");
        expect_at(base + 1601, A_MAX_Y, 1, "a_max_y");
        step_to(base + 1603);

        #0 rst_b = 1'b0;
        base_b = cyc;
        expect_at(base_b, B_X, 0, "b_rst_x");
        expect_at(base_b, B_Y, 0, "b_rst_y");
        expect_at(base_b, B_PIX, 0, "b_rst_pix");
        expect_at(base_b, B_HS, 1, "b_rst_hs");
        expect_at(base_b, B_VS, 1, "b_rst_vs");
        expect_at(base_b, B_BLANK, 1, "b_rst_blank");
        expect_at(base_b, B_FS, 0, "b_rst_fs");
        expect_at(base_b + 15, B_BLANK, 1, "b_blank_x7");
        expect_at(base_b + 16, B_BLANK, 0, "b_blank_x8");
        expect_at(base_b + 19, B_HS, 1, "b_hs_x9");
        expect_at(base_b + 20, B_HS, 0, "b_hs_x10");
        expect_at(base_b + 120, B_BLANK, 0, "b_blank_y4");
        expect_at(base_b + 120, B_Y, 4, "b_y_4");
        expect_at(base_b + 149, B_VS, 1, "b_vs_y4");
        expect_at(base_b + 150, B_VS, 0, "b_vs_y5");
        expect_at(base_b + 150, B_Y, 5, "b_y_5");
        expect_at(base_b + 209, B_VS, 0, "b_vs_y6");
        expect_at(base_b + 210, B_VS, 1, "b_vs_y7");
        expect_at(base_b + 240, B_Y, 8, "b_y_8");
        expect_at(base_b + 268, B_LE, 0, "b_le_pix0");
        expect_at(base_b + 269, B_LE, 1, "b_le_last");
        expect_at(base_b + 269, B_X, 14, "b_x_last");
        expect_at(base_b + 269, B_Y, 8, "b_y_last");
        expect_at(base_b + 269, B_BLANK, 0, "b_blank_last");
        expect_at(base_b + 269, B_FS, 0, "b_fs_before");
        expect_at(base_b + 270, B_FS, 1, "b_fs_wrap");
        expect_at(base_b + 270, B_X, 0, "b_x_wrap");
        expect_at(base_b + 270, B_Y, 0, "b_y_wrap");
        expect_at(base_b + 270, B_FS_CNT, 0, "b_fs_cnt_pre");
        expect_at(base_b + 270, B_BLANK_HI, 64, "b_blank_hi_frame");
        expect_at(base_b + 271, B_FS, 0, "b_fs_one_clk");
        expect_at(base_b + 271, B_FS_CNT, 1, "b_fs_cnt_frame");
        expect_at(base_b + 271, B_VS_LOW, 60, "b_vs_low_clk");
        expect_at(base_b + 271, B_MAX_X, 14, "b_max_x");
        expect_at(base_b + 271, B_MAX_Y, 8, "b_max_y");
        expect_at(base_b + 472, B_X, 11, "b_x_pre_rst");
        expect_at(base_b + 472, B_Y, 6, "b_y_pre_rst");
        expect_at(base_b + 472, B_HS, 0, "b_hs_pre_rst");
        expect_at(base_b + 472, B_VS, 0, "b_vs_pre_rst");
        step_to(base_b + 472);
        rst_b = 1'b1;
        @(posedge clk);
        #1 rst_b = 1'b0;
        base2 = cyc;
        expect_at(base2, B_X, 0, "b_mid_rst_x");
        expect_at(base2, B_Y, 0, "b_mid_rst_y");
        expect_at(base2, B_HS, 1, "b_mid_rst_hs");
        expect_at(base2, B_VS, 1, "b_mid_rst_vs");
        expect_at(base2, B_FS, 0, "b_mid_rst_fs");
        expect_at(base2, B_PIX, 0, "b_mid_rst_pix");
        expect_at(base2, B_BLANK, 1, "b_mid_rst_blank");
        expect_at(base2 + 2, B_X, 1, "b_mid_x_c2");
        expect_at(base2 + 269, B_FS, 0, "b_mid_fs_before");
        expect_at(base2 + 270, B_FS, 1, "b_mid_fs_frame");
        expect_at(base2 + 271, B_FS_CNT, 1, "b_mid_fs_cnt");
        expect_at(base2 + 272, A_SYNCN_CNT, 0, "a_syncn_never_high");
        expect_at(base2 + 272, B_SYNCN_CNT, 0, "b_syncn_never_high");
        step_to(base2 + 275);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Generates the raster scan for the 640x480@60 Hz display from the 50 MHz system clock.
- Drives DrawX/DrawY to the per-pixel renderers (background, sprites), plus HS/VS/blank/sync to the VGA DAC.
- Renderers are combinational on DrawX/DrawY and sample on pix_en.
- Also supplies frame/line boundary pulses so game logic can update once per frame.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines); V_TOTAL = sum = 525

Ports:
- Clk  in  1  50 MHz system clock
- Reset  in  1  synchronous, active-high reset
- pix_en  out  1  pixel-clock enable, high every second Clk cycle (25 MHz pixel rate); also drives VGA_CLK
- DrawX  out  10  horizontal counter, 0..H_TOTAL-1
- DrawY  out  10  vertical counter, 0..V_TOTAL-1
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  high when DrawX<H_VISIBLE and DrawY<V_VISIBLE
- VGA_SYNC_N  out  1  tied 0 (sync-on-green unused)
- line_end  out  1  one-Clk pulse on the pix_en cycle where DrawX=H_TOTAL-1
- frame_start  out  1  one-Clk pulse on the first Clk cycle where DrawX=0, DrawY=0 after a wrap

Behaviour:
- Single clock domain (Clk). Reset is synchronous and active-high; all state is registered.
- Reset values (the Clk cycle after Reset is sampled high):
  - pix_en=0, DrawX=0, DrawY=0
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=1
  - line_end=0, frame_start=0
- pix_en register:
  - toggles every Clk while Reset=0;
  - first high cycle is the second Clk after Reset deasserts.
- Counter advance occurs only on a Clk edge where pix_en=1:
  - DrawX increments; at H_TOTAL-1 it wraps to 0 and DrawY increments.
  - DrawY wraps from V_TOTAL-1 to 0 when DrawX also wraps.
  - Counters hold on Clk edges where pix_en=0, so each pixel value lasts exactly 2 Clk.
- Counters are 10-bit unsigned. Values >= H_TOTAL / V_TOTAL are never produced.
- VGA_HS, VGA_VS and VGA_BLANK_N are registered from the next counter values, so they are aligned with DrawX/DrawY, with no skew:
  - VGA_HS=0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - VGA_VS=0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
  - VGA_BLANK_N=0 in every porch/sync region.
- line_end: high for the single Clk in which pix_en=1 and DrawX=H_TOTAL-1; low otherwise.
- frame_start:
  - high for one Clk, the cycle in which DrawX/DrawY first read (0,0) after a wrap from (799,524);
  - not asserted on the (0,0) produced by Reset.
- Reset mid-frame: the next Clk forces all reset values regardless of counter position or pix_en phase. No pulse is emitted on that cycle.
- Timing totals:
  - line period = 1600 Clk;
  - frame period = 840000 Clk;
  - one HS low pulse = 192 Clk;
  - one VS low pulse = 3200 Clk.

Test Plan:
- Reset held 3 cycles then released -> all outputs at reset values; pix_en pattern 0,1,0,1 starting the cycle after release; DrawX reaches 1 on the second pix_en edge.
- Run 1600 Clk from reset -> DrawX returns to 0, DrawY=1; line_end high exactly once; VGA_HS low for exactly 192 consecutive Clk, starting when DrawX=656.
- Run one full frame (840000 Clk) -> DrawY sequence 0..524 then 0; VGA_VS low for exactly 3200 Clk at DrawY 490..491; frame_start high exactly once, at the wrap to (0,0).
- Blanking check across a frame -> VGA_BLANK_N high for exactly 640*480*2 = 614400 Clk; low at (640,0), (0,480), and (799,524).
- Assert Reset for 1 Clk at DrawX=700, DrawY=491 (inside both syncs) -> next cycle DrawX=0, DrawY=0, VGA_HS=1, VGA_VS=1, frame_start=0; the following frame_start arrives 840000 Clk later.
- Throughout all runs -> VGA_SYNC_N constant 0; DrawX never exceeds 799; DrawY never exceeds 524.
